// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, access widths and byte-enable helper for the memory stage
package mem_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic [1:0] {W_NONE, W_WORD, W_HALF, W_BYTE} width_e;

  function automatic logic [3:0] byte_en(input width_e w, input logic [1:0] off);
    return w == W_WORD ? 4'b1111 :
           w == W_HALF ? 4'b0011 << {off[1], 1'b0} :
           w == W_BYTE ? 4'b0001 << off : 4'b0000;
  endfunction

endpackage

// File: rtl/mem_stage_dm_byte_ctrl.sv
// dm_byte_ctrl: opcode decode, alignment check, store lane merge and load extension
module dm_byte_ctrl
  import mem_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        store,
  output logic        align_err,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  width_e      width;
  logic        load;
  logic        sgn;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [15:0] half;
  logic [7:0]  byte_v;

  // decode the primary opcode into access width, direction and signedness
  always_comb begin
    width = W_NONE;
    store = 1'b0;
    load  = 1'b0;
    sgn   = 1'b0;
    case (op)
      OP_SW:   begin width = W_WORD; store = 1'b1; end
      OP_SH:   begin width = W_HALF; store = 1'b1; end
      OP_SB:   begin width = W_BYTE; store = 1'b1; end
      OP_LW:   begin width = W_WORD; load = 1'b1; end
      OP_LH:   begin width = W_HALF; load = 1'b1; sgn = 1'b1; end
      OP_LHU:  begin width = W_HALF; load = 1'b1; end
      OP_LB:   begin width = W_BYTE; load = 1'b1; sgn = 1'b1; end
      OP_LBU:  begin width = W_BYTE; load = 1'b1; end
      default: ;
    endcase
  end

  assign align_err = (width == W_WORD && off != 2'b00) || (width == W_HALF && off[0]);
  assign be        = store ? byte_en(width, off) : 4'b0000;
  assign wrep      = width == W_WORD ? wdata :
                     width == W_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
  end

  assign half      = off[1] ? rword[31:16] : rword[15:0];
  assign byte_v    = off[0] ? half[15:8] : half[7:0];
  assign load_data = (!load || align_err) ? 32'h0 :
                     width == W_WORD ? rword :
                     width == W_HALF ? {{16{sgn & half[15]}}, half} :
                                       {{24{sgn & byte_v[7]}}, byte_v};

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data memory access and M/W pipeline register of the five-stage pipeline
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_AW   = 10,
  parameter int DUMP_EN = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] AluResult_In,
  input  logic [31:0] WriteData_In,
  input  logic        Fwd_Rt_Sel,
  input  logic [31:0] Fwd_Rt_Data,
  input  logic [4:0]  WriteReg_In,
  input  logic        RegWrite_In,
  input  logic        MemtoReg_In,
  input  logic        MemWrite_In,
  input  logic        Jal_In,
  input  logic [31:0] Pc_In,
  input  logic [1:0]  Tnew_In,
  input  logic [5:0]  Op_In,
  output logic [31:0] AluResult_Out,
  output logic [31:0] ReadData_Out,
  output logic [4:0]  WriteReg_Out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic        Jal_Out,
  output logic [31:0] Pc_Out,
  output logic [1:0]  Tnew_Out,
  output logic        AlignErr_Out
);

  localparam int DEPTH = 2 ** DM_AW;

  logic [31:0]      dm [DEPTH];
  logic [DM_AW-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      wdata;
  logic [31:0]      merged;
  logic [31:0]      load_data;
  logic             store;
  logic             align_err;
  logic             commit;

  assign idx    = AluResult_In[DM_AW+1:2];
  assign rword  = dm[idx];
  assign wdata  = Fwd_Rt_Sel ? Fwd_Rt_Data : WriteData_In;
  assign commit = MemWrite_In && store && !align_err;

  dm_byte_ctrl u_ctrl (
    .op        (Op_In),
    .off       (AluResult_In[1:0]),
    .wdata     (wdata),
    .rword     (rword),
    .store     (store),
    .align_err (align_err),
    .merged    (merged),
    .load_data (load_data)
  );

  // falling-edge data memory: reset clears every word, otherwise commit aligned stores
  always_ff @(negedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= '0;
    end else if (commit) begin
      dm[idx] <= merged;
      if (DUMP_EN != 0) $write("@%h: *%h <= %h\n", Pc_In, {AluResult_In[31:2], 2'b00}, merged);
    end
  end

  // M/W pipeline register; a misaligned access drops its register write
  always_ff @(negedge Clk) begin
    if (!Reset) begin
      AluResult_Out <= '0;
      ReadData_Out  <= '0;
      WriteReg_Out  <= '0;
      RegWrite_Out  <= 1'b0;
      MemtoReg_Out  <= 1'b0;
      Jal_Out       <= 1'b0;
      Pc_Out        <= '0;
      Tnew_Out      <= '0;
      AlignErr_Out  <= 1'b0;
    end else begin
      AluResult_Out <= AluResult_In;
      ReadData_Out  <= load_data;
      WriteReg_Out  <= WriteReg_In;
      RegWrite_Out  <= RegWrite_In && !align_err;
      MemtoReg_Out  <= MemtoReg_In;
      Jal_Out       <= Jal_In;
      Pc_Out        <= Pc_In;
      Tnew_Out      <= Tnew_In == 2'd0 ? 2'd0 : Tnew_In - 2'd1;
      AlignErr_Out  <= align_err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of stores, loads, alignment, forwarding and Tnew
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] AluResult_In, WriteData_In, Fwd_Rt_Data, Pc_In;
  logic        Fwd_Rt_Sel, RegWrite_In, MemtoReg_In, MemWrite_In, Jal_In;
  logic [4:0]  WriteReg_In;
  logic [1:0]  Tnew_In;
  logic [5:0]  Op_In;
  logic [31:0] AluResult_Out, ReadData_Out, Pc_Out;
  logic [4:0]  WriteReg_Out;
  logic        RegWrite_Out, MemtoReg_Out, Jal_Out, AlignErr_Out;
  logic [1:0]  Tnew_Out;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DM_AW(10), .DUMP_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .AluResult_In(AluResult_In), .WriteData_In(WriteData_In),
    .Fwd_Rt_Sel(Fwd_Rt_Sel), .Fwd_Rt_Data(Fwd_Rt_Data), .WriteReg_In(WriteReg_In),
    .RegWrite_In(RegWrite_In), .MemtoReg_In(MemtoReg_In), .MemWrite_In(MemWrite_In),
    .Jal_In(Jal_In), .Pc_In(Pc_In), .Tnew_In(Tnew_In), .Op_In(Op_In),
    .AluResult_Out(AluResult_Out), .ReadData_Out(ReadData_Out), .WriteReg_Out(WriteReg_Out),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out), .Jal_Out(Jal_Out),
    .Pc_Out(Pc_Out), .Tnew_Out(Tnew_Out), .AlignErr_Out(AlignErr_Out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic mw, input logic rw);
    Op_In        = op;
    AluResult_In = a;
    WriteData_In = d;
    MemWrite_In  = mw;
    RegWrite_In  = rw;
    MemtoReg_In  = rw && !mw;
    Pc_In        = Pc_In + 32'd4;
  endtask

  initial begin
    Reset = 1'b0; Fwd_Rt_Sel = 1'b0; Fwd_Rt_Data = '0; WriteReg_In = 5'd7;
    Jal_In = 1'b0; Tnew_In = 2'd0; Pc_In = 32'h0000_3000;
    instr(6'h2B, 32'h10, 32'h1234_5678, 1'b1, 1'b0);
    step();
    chk("rst0_alu", AluResult_Out, 32'h0);
    chk("rst0_rd", ReadData_Out, 32'h0);
    step();
    chk("rst1_rd", ReadData_Out, 32'h0);
    chk("rst1_pc", Pc_Out, 32'h0);
    Reset = 1'b1;
    step();
    chk("sw_alu", AluResult_Out, 32'h10);
    chk("sw_pc", Pc_Out, 32'h0000_3004);
    chk("sw_rd", ReadData_Out, 32'h0);
    instr(6'h23, 32'h10, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw10", ReadData_Out, 32'h1234_5678);
    chk("lw10_wreg", WriteReg_Out, 32'd7);
    chk("lw10_rw", RegWrite_Out, 32'd1);
    chk("lw10_m2r", MemtoReg_Out, 32'd1);
    instr(6'h28, 32'h21, 32'h1234_56AB, 1'b1, 1'b0);
    step();
    instr(6'h23, 32'h20, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw20", ReadData_Out, 32'h0000_AB00);
    instr(6'h20, 32'h21, 32'h0, 1'b0, 1'b1);
    step();
    chk("lb21", ReadData_Out, 32'hFFFF_FFAB);
    instr(6'h24, 32'h21, 32'h0, 1'b0, 1'b1);
    step();
    chk("lbu21", ReadData_Out, 32'h0000_00AB);
    instr(6'h20, 32'h23, 32'h0, 1'b0, 1'b1);
    step();
    chk("lb23", ReadData_Out, 32'h0);
    instr(6'h29, 32'h32, 32'hFFFF_8001, 1'b1, 1'b0);
    step();
    instr(6'h23, 32'h30, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw30", ReadData_Out, 32'h8001_0000);
    instr(6'h21, 32'h32, 32'h0, 1'b0, 1'b1);
    step();
    chk("lh32", ReadData_Out, 32'hFFFF_8001);
    instr(6'h25, 32'h32, 32'h0, 1'b0, 1'b1);
    step();
    chk("lhu32", ReadData_Out, 32'h0000_8001);
    instr(6'h2B, 32'h13, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step();
    chk("sw13_aerr", AlignErr_Out, 32'd1);
    chk("sw13_rw", RegWrite_Out, 32'd0);
    instr(6'h23, 32'h10, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw10_after", ReadData_Out, 32'h1234_5678);
    chk("lw10_aerr", AlignErr_Out, 32'd0);
    chk("lw10_rw2", RegWrite_Out, 32'd1);
    instr(6'h23, 32'h12, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw12_rd", ReadData_Out, 32'h0);
    chk("lw12_aerr", AlignErr_Out, 32'd1);
    instr(6'h21, 32'h31, 32'h0, 1'b0, 1'b1);
    step();
    chk("lh31_aerr", AlignErr_Out, 32'd1);
    chk("lh31_rd", ReadData_Out, 32'h0);
    Fwd_Rt_Sel = 1'b1; Fwd_Rt_Data = 32'hCAFE_F00D;
    instr(6'h2B, 32'h40, 32'h0, 1'b1, 1'b0);
    step();
    Fwd_Rt_Sel = 1'b0;
    instr(6'h23, 32'h40, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw40_fwd", ReadData_Out, 32'hCAFE_F00D);
    instr(6'h2B, 32'h1044, 32'h55AA_55AA, 1'b1, 1'b0);
    step();
    instr(6'h23, 32'h44, 32'h0, 1'b0, 1'b1);
    step();
    chk("lw44_wrap", ReadData_Out, 32'h55AA_55AA);
    instr(6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    Tnew_In = 2'd2; Jal_In = 1'b1;
    step();
    chk("tnew2", Tnew_Out, 32'd1);
    chk("jal", Jal_Out, 32'd1);
    chk("nop_rd", ReadData_Out, 32'h0);
    Tnew_In = 2'd1; Jal_In = 1'b0;
    step();
    chk("tnew1", Tnew_Out, 32'd0);
    Tnew_In = 2'd0;
    step();
    chk("tnew0", Tnew_Out, 32'd0);
    Tnew_In = 2'd3;
    step();
    chk("tnew3", Tnew_Out, 32'd2);
    instr(6'h23, 32'h40, 32'h0, 1'b0, 1'b1);
    Tnew_In = 2'd2; Jal_In = 1'b1; Reset = 1'b0;
    step();
    chk("rstm_tnew", Tnew_Out, 32'd0);
    chk("rstm_jal", Jal_Out, 32'd0);
    chk("rstm_pc", Pc_Out, 32'h0);
    chk("rstm_rd", ReadData_Out, 32'h0);
    chk("rstm_rw", RegWrite_Out, 32'd0);
    Reset = 1'b1; Tnew_In = 2'd0; Jal_In = 1'b0;
    step();
    chk("lw40_cleared", ReadData_Out, 32'h0);
    chk("lw40_alu", AluResult_Out, 32'h40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-stage block of the P6 five-stage MIPS pipeline.
- Consumes the E/M pipeline register outputs and performs the data-memory access: word, half and byte stores; signed and unsigned loads.
- Latches the M/W pipeline register feeding write-back.
- Decrements Tnew so the hazard unit sees the correct remaining latency in W.

Parameters:
DM_AW, 10, data-memory word-address width (DM depth = 2**DM_AW words = 4 KiB)
DUMP_EN, 1, when 1, each committed store prints a trace line

Ports:
Clk  input  1  pipeline clock; all state updates on falling edge, matching the other pipeline registers
Reset  input  1  synchronous, active-low reset; sampled on falling edge of Clk
AluResult_In  input  32  effective address, or ALU result for non-memory instructions
WriteData_In  input  32  store data from E/M
Fwd_Rt_Sel  input  1  1 = use Fwd_Rt_Data as store data (W→M forward)
Fwd_Rt_Data  input  32  forwarded write-back value
WriteReg_In  input  5  destination register
RegWrite_In  input  1  register-write enable
MemtoReg_In  input  1  write-back selects load data
MemWrite_In  input  1  store enable
Jal_In  input  1  jal marker
Pc_In  input  32  instruction PC
Tnew_In  input  2  remaining cycles until result is ready
Op_In  input  6  primary opcode
AluResult_Out  output  32  registered ALU result
ReadData_Out  output  32  registered, extended load data
WriteReg_Out  output  5  registered destination register
RegWrite_Out  output  1  registered write enable (0 on align error)
MemtoReg_Out  output  1  registered
Jal_Out  output  1  registered
Pc_Out  output  32  registered
Tnew_Out  output  2  registered, decremented Tnew
AlignErr_Out  output  1  registered misalignment flag

Behaviour:
- Reset (Reset==0 at a falling edge):
  - all outputs become 0.
  - all DM words become 0 in the same edge.
  - no store is committed that cycle, even if MemWrite_In=1.
- Store data: Fwd_Rt_Sel ? Fwd_Rt_Data : WriteData_In.
- Word index: AluResult_In[DM_AW+1:2]; upper address bits ignored, so out-of-range addresses wrap modulo depth. Byte offset is AluResult_In[1:0].
- Opcode decoding:
  - stores: sw 0x2B, sh 0x29, sb 0x28.
  - loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - other opcodes: no memory access; ReadData_Out=0.
- Store byte enables (sw and sh require alignment):
  - sw: 4'b1111.
  - sh: 4'b0011 << {a[1],1'b0}.
  - sb: 4'b0001 << a[1:0].
  - Data lanes are replicated (half ×2, byte ×4) and merged under the byte enables; unenabled bytes keep their old value.
- Store commit: at the falling edge when Reset==1, MemWrite_In==1 and the access is aligned.
- Load:
  - Combinational read of the addressed word; the lane is selected by offset.
  - lh and lb sign-extend; lhu and lbu zero-extend.
  - Result registered into ReadData_Out at the same edge: 1-cycle latency M→W.
- Read/write ordering: the load read and the store write never belong to the same instruction. A read of the word being written returns the pre-write contents.
- Misalignment:
  - Condition: lw/sw with a[1:0]≠0, or lh/lhu/sh with a[0]≠0.
  - Store suppressed; ReadData_Out=0; RegWrite_Out=0; AlignErr_Out=1 for that instruction only.
- Pipeline latch: all *_In fields pass to *_Out each non-reset falling edge.
- Tnew_Out: Tnew_In-1 if Tnew_In≠0, else 0 (saturating).
- Trace: with DUMP_EN=1, each committed store prints "@%h: *%h <= %h" giving Pc_In, word-aligned address, and full merged word after the write.
- No stall or flush input: the hazard unit freezes stages upstream and inserts bubbles (all-zero controls) into E/M.

Decomposition:
- Shared package:
  - opcode constants OP_LW…OP_SB.
  - width encoding (WORD/HALF/BYTE).
  - a function returning byte enables from width and offset.
- One natural sub-module: dm_byte_ctrl (combinational), covering decode, alignment check, byte-enable/lane merge and load extension.
- mem_stage holds the RAM array and the M/W registers.

Test Plan:
- Reset held low 2 cycles, then sw 0x12345678 to 0x10 → ReadData_Out=0 during reset. After release, lw 0x10 gives ReadData_Out=0x12345678 one falling edge later. Trace printed once.
- sb 0xAB to 0x21, then lb 0x21 and lbu 0x21 → word@0x20=0x0000AB00; lb=0xFFFFFFAB; lbu=0x000000AB.
- sh 0x8001 to 0x32, then lh and lhu 0x32 → word@0x30=0x80010000; lh=0xFFFF8001; lhu=0x00008001.
- sw to 0x13 with RegWrite_In=1 → memory unchanged; AlignErr_Out=1 and RegWrite_Out=0 for one cycle; next aligned instruction clears AlignErr_Out.
- Fwd_Rt_Sel=1, Fwd_Rt_Data=0xCAFEF00D, WriteData_In=0 on sw 0x40 → lw 0x40 returns 0xCAFEF00D.
- Tnew_In = 2, 1, 0 on consecutive cycles → Tnew_Out = 1, 0, 0; Reset low mid-sequence → all outputs 0 at that edge.
